// File: rtl/conv_mac_seq_if.sv
// rtl/conv_mac_seq_if.sv - start/operand inputs and result handshake of the 3x3 MAC engine
interface conv_mac_seq_if;
  logic        convRst;
  logic [71:0] scope;
  logic [71:0] kernel;
  logic        resultReady;
  logic [19:0] result;
  logic        resultValid;
  logic        busy;

  // Operation controller / output collector side
  modport master (
    output convRst, scope, kernel, resultReady,
    input  result, resultValid, busy
  );

  // MAC engine side
  modport slave (
    input  convRst, scope, kernel, resultReady,
    output result, resultValid, busy
  );
endinterface

// File: rtl/conv_mac_seq.sv
// rtl/conv_mac_seq.sv - sequential 9-tap signed 8-bit dot product, one MAC per cycle
module conv_mac_seq (
  input logic           clk,
  input logic           rst,
  conv_mac_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [71:0]        scope_snap;
  logic [71:0]        kernel_snap;
  logic [3:0]         idx;
  logic signed [19:0] acc;
  logic [19:0]        result_q;
  logic               valid_q;
  logic               busy_q;

  logic signed [7:0]  tap_s;
  logic signed [7:0]  tap_k;
  logic signed [15:0] prod;
  logic signed [19:0] prod_ext;
  logic signed [19:0] sum;

  // Select the current tap pair from the snapshots; idx never exceeds 8 while running
  always_comb begin
    tap_s = '0;
    tap_k = '0;
    for (int i = 0; i < 9; i++) begin
      if (idx == 4'(i)) begin
        tap_s = scope_snap[8*i +: 8];
        tap_k = kernel_snap[8*i +: 8];
      end
    end
  end

  // 9 x (-128 * -128) fits in 20 signed bits, so the plain sum never wraps
  assign prod     = tap_s * tap_k;
  assign prod_ext = {{4{prod[15]}}, prod};
  assign sum      = acc + prod_ext;

  // Control FSM: restart beats handshake, handshake beats sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      scope_snap  <= '0;
      kernel_snap <= '0;
      idx         <= '0;
      acc         <= '0;
      result_q    <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else if (bus.convRst) begin
      state       <= RUN;
      scope_snap  <= bus.scope;
      kernel_snap <= bus.kernel;
      idx         <= '0;
      acc         <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (idx == 4'd8) begin
            result_q <= sum;
            state    <= DONE;
            valid_q  <= 1'b1;
            busy_q   <= 1'b0;
          end else begin
            acc <= sum;
            idx <= idx + 4'd1;
          end
        end
        DONE: begin
          if (bus.resultReady) begin
            state   <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result      = result_q;
  assign bus.resultValid = valid_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_conv_mac_seq.sv
// tb/tb_conv_mac_seq.sv - directed checks of conv_mac_seq
module tb_conv_mac_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  conv_mac_seq_if bus ();

  conv_mac_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [71:0] fill(input logic [7:0] v);
    return {9{v}};
  endfunction

  // Called at a falling edge: present operands with convRst so the next rising edge is E0
  task automatic start(input logic [71:0] s, input logic [71:0] k);
    bus.scope   = s;
    bus.kernel  = k;
    bus.convRst = 1'b1;
    @(negedge clk);
    bus.convRst = 1'b0;
  endtask

  // Counts falling edges until resultValid; returns -1 if it never comes
  task automatic wait_valid(input int already, output int cycles);
    cycles = -1;
    for (int k = already + 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus.resultValid) begin
        cycles = k;
        return;
      end
    end
  endtask

  task automatic ack();
    bus.resultReady = 1'b1;
    @(negedge clk);
    bus.resultReady = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (bus.result !== 20'h0) begin n_fail++; $display("FAIL reset_result: got %h want 00000", bus.result); end
    n_cmp++; if (bus.resultValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.resultValid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_basic();
    int cyc;
    start(72'h090807060504030201, fill(8'd1));
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", bus.busy); end
    wait_valid(0, cyc);
    n_cmp++; if (cyc !== 9) begin n_fail++; $display("FAIL basic_latency: got %0d want 9", cyc); end
    n_cmp++; if (bus.result !== 20'd45) begin n_fail++; $display("FAIL basic_result: got %0d want 45", bus.result); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_done: got %b want 0", bus.busy); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.resultValid !== 1'b1 || bus.result !== 20'd45) begin
        n_fail++;
        $display("FAIL basic_hold[%0d]: got valid=%b result=%0d want valid=1 result=45", i, bus.resultValid, bus.result);
      end
    end
    ack();
  endtask

  task automatic test_signed();
    int cyc;
    start(fill(8'h80), fill(8'h80));
    wait_valid(0, cyc);
    n_cmp++; if (cyc !== 9) begin n_fail++; $display("FAIL signed_a_latency: got %0d want 9", cyc); end
    n_cmp++; if (bus.result !== 20'h24000) begin n_fail++; $display("FAIL signed_a_result: got %h want 24000", bus.result); end
    ack();
    start(fill(8'h80), fill(8'h7f));
    wait_valid(0, cyc);
    n_cmp++; if (bus.result !== 20'hDC480) begin n_fail++; $display("FAIL signed_b_result: got %h want dc480", bus.result); end
    ack();
    // elements 1..9 against weight -2: -2*45 = -90
    start(72'h090807060504030201, fill(8'hfe));
    wait_valid(0, cyc);
    n_cmp++; if (bus.result !== 20'hFFFA6) begin n_fail++; $display("FAIL signed_mixed_result: got %h want fffa6", bus.result); end
    ack();
  endtask

  task automatic test_snapshot();
    int cyc;
    start(fill(8'd3), fill(8'd2));
    repeat (2) @(negedge clk);
    bus.scope  = '0;
    bus.kernel = '0;
    wait_valid(2, cyc);
    n_cmp++; if (cyc !== 9) begin n_fail++; $display("FAIL snapshot_latency: got %0d want 9", cyc); end
    n_cmp++; if (bus.result !== 20'd54) begin n_fail++; $display("FAIL snapshot_result: got %0d want 54", bus.result); end
    ack();
  endtask

  task automatic test_restart();
    int cyc;
    start(fill(8'd2), fill(8'd2));
    repeat (4) @(negedge clk);
    start(fill(8'd1), fill(8'd1));
    n_cmp++; if (bus.resultValid !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL restart_state: got valid=%b busy=%b want valid=0 busy=1", bus.resultValid, bus.busy); end
    n_cmp++; if (bus.result !== 20'd54) begin n_fail++; $display("FAIL restart_keep: got %0d want 54", bus.result); end
    wait_valid(0, cyc);
    n_cmp++; if (cyc !== 9) begin n_fail++; $display("FAIL restart_latency: got %0d want 9", cyc); end
    n_cmp++; if (bus.result !== 20'd9) begin n_fail++; $display("FAIL restart_result: got %0d want 9", bus.result); end
  endtask

  task automatic test_handshake();
    int cyc;
    // left in DONE with result 9 by the restart scenario
    ack();
    n_cmp++; if (bus.resultValid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL hs_release: got valid=%b busy=%b want 0 0", bus.resultValid, bus.busy); end
    bus.resultReady = 1'b1;
    repeat (3) @(negedge clk);
    bus.resultReady = 1'b0;
    n_cmp++; if (bus.resultValid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL hs_idle_ready: got valid=%b busy=%b want 0 0", bus.resultValid, bus.busy); end
    // collision: convRst with resultReady in DONE
    start(fill(8'd1), fill(8'd1));
    wait_valid(0, cyc);
    bus.resultReady = 1'b1;
    start(fill(8'd2), fill(8'd1));
    bus.resultReady = 1'b0;
    n_cmp++; if (bus.resultValid !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL hs_collide: got valid=%b busy=%b want 0 1", bus.resultValid, bus.busy); end
    wait_valid(0, cyc);
    n_cmp++; if (cyc !== 9 || bus.result !== 20'd18) begin n_fail++; $display("FAIL hs_collide_run: got cycles=%0d result=%0d want 9 18", cyc, bus.result); end
    // convRst alone in DONE drops the pending result
    start(fill(8'd3), fill(8'd1));
    n_cmp++; if (bus.resultValid !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL hs_drop: got valid=%b busy=%b want 0 1", bus.resultValid, bus.busy); end
    wait_valid(0, cyc);
    n_cmp++; if (bus.result !== 20'd27) begin n_fail++; $display("FAIL hs_drop_run: got %0d want 27", bus.result); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    start(fill(8'd1), fill(8'd1));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (bus.result !== 20'h0) begin n_fail++; $display("FAIL rstmid_result: got %0d want 0", bus.result); end
    n_cmp++; if (bus.resultValid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags: got valid=%b busy=%b want 0 0", bus.resultValid, bus.busy); end
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.resultValid || bus.busy) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet: got activity=%b want 0", seen); end
  endtask

  initial begin
    bus.convRst     = 1'b0;
    bus.scope       = '0;
    bus.kernel      = '0;
    bus.resultReady = 1'b0;
    test_reset();
    test_basic();
    test_signed();
    test_snapshot();
    test_restart();
    test_handshake();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_mac_seq.md
# conv_mac_seq

Sequential 3x3 multiply-accumulate engine that sits directly downstream of the CAU operation controller. It consumes the 72-bit scope and kernel registers and the one-cycle convRst pulse the controller produces on every load or clear. It computes the 9-tap signed dot product using one multiplier over 9 cycles, then presents the result on a valid/ready handshake toward the CAU output collector.

## Interface
- No parameters. Element width is fixed at 8 bits, with 9 taps and a 20-bit result.
- clk  in  1  Single clock. All state updates on the rising edge.
- rst  in  1  Reset: synchronous, active-high.
- convRst  in  1  Start/restart strobe from the operation controller. One clock period wide.
- scope  in  72  9 signed 8-bit image elements. Element i occupies bits [8i+7:8i].
- kernel  in  72  9 signed 8-bit weights, same packing as scope.
- resultReady  in  1  Downstream accepts the result.
- result  out  20  Signed two's-complement dot product of the last completed run.
- resultValid  out  1  result holds a completed, unconsumed value.
- busy  out  1  Accumulation in progress.

## Operation
- FSM states are IDLE, RUN and DONE. Reset puts the FSM in IDLE.
- Internal registers:
  - scopeSnap and kernelSnap (72 bits each), captured at start.
  - idx (4 bits).
  - acc (20 bits signed).
  - result register.
- Start event is convRst=1 at a rising edge, in any state. On start:
  - scopeSnap <= scope and kernelSnap <= kernel.
  - acc <= 0 and idx <= 0.
  - State goes to RUN.
- Snapshotting is mandatory. Later changes on scope and kernel must not affect a run in progress.
- RUN: each edge computes acc <= acc + sext(scopeSnap[idx]) * sext(kernelSnap[idx]) and idx <= idx+1.
  - Each product is a signed 8x8 to 16 bits, sign-extended to 20 bits.
  - When idx==8, the final sum is written to result instead of acc.
  - In the same edge, state goes to DONE and resultValid is set to 1.
- DONE: resultValid stays 1, and result is stable, until resultReady=1 at an edge. Then resultValid goes to 0 and state goes to IDLE.
- Width rule: the worst case is 9 x 16384 = 147456 < 2^19, so a 20-bit signed result never overflows. There is no saturation.
- Priority for simultaneous events, from highest to lowest:
  - rst.
  - convRst.
  - resultReady.
  - Normal sequencing.
- Boundary cases:
  - convRst during RUN: the current run is abandoned and a restart happens with fresh snapshots. result keeps its previous value and resultValid stays 0.
  - convRst during DONE without resultReady: the pending result is dropped. resultValid goes to 0 on that edge and a new run starts.
  - convRst and resultReady together in DONE: the transfer counts as completed and the new run starts. resultValid goes to 0.
  - resultReady in IDLE or RUN: ignored.
  - rst mid-run: all state and outputs return to reset values on that edge. No result is produced.
- An all-zero scope/kernel (the controller's CLEAR op) is not special-cased. It runs normally and yields result 0.

## Timing
- Reset values:
  - result = 0.
  - resultValid = 0.
  - busy = 0.
  - acc = 0, idx = 0, snapshots = 0.
  - State is IDLE.
- The upstream controller updates scope/kernel and raises convRst on the falling edge. Both are therefore stable at the following rising edge (edge E0).
- E0 samples convRst. busy=1 from after E0.
- Edges E1 through E9 perform the 9 MACs. After E9, resultValid=1, busy=0, and result is final.
- Latency is 9 cycles from the convRst sample to resultValid. Throughput is one result per 10 cycles when resultReady is held high.
- resultReady=1 at E9+1 clears resultValid after that edge.
- busy = (state==RUN). resultValid = (state==DONE). Both are registered, with no combinational path from inputs.

## Test plan
- Basic case:
  - Stimulus: scope elements 1..9 (element 0 = 1), kernel all 1, convRst pulse, resultReady=0.
  - Required response: result=45 and resultValid=1 exactly 9 edges after the convRst sample. Both hold for 20 cycles.
- Signed extremes:
  - Stimulus A: scope and kernel all -128 (0x80).
  - Required response A: result = 147456 (0x24000).
  - Stimulus B: scope all -128, kernel all 127.
  - Required response B: result = -146304 (0xDC480 in 20 bits).
- Snapshot:
  - Stimulus: start with kernel all 2 and scope all 3. Change both buses to all 0 at E3.
  - Required response: result=54.
- Restart mid-run:
  - Stimulus: convRst again at E5 of a run, with new scope all 1 and kernel all 1.
  - Required response: no resultValid from the first run, and result=9 valid 9 edges after the second convRst.
- Handshake and collision:
  - Stimulus 1: in DONE, raise resultReady.
  - Required response 1: resultValid drops after one edge and the state is IDLE.
  - Stimulus 2: in DONE, raise convRst and resultReady together.
  - Required response 2: resultValid=0 and busy=1 on the next cycle.
- Reset mid-run:
  - Stimulus: rst=1 at E4.
  - Required response: result=0, resultValid=0 and busy=0 after that edge. Nothing is produced until a new convRst.
